decode_stage: RTL and testbench

- Registered, parametrised instruction-decode pipeline stage for the 16-bit datapath CPU.
- Sits between fetch and the register file/function unit.
- Decodes the opcode into register, immediate and control fields and holds them in one output register with a valid/ready handshake.
- Adds three things over a combinational decoder: load-use hazard stall, a HALT state with resume, and an instruction counter.

---
 rtl/decode_stage_if.sv | 52 +++++
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundle of the fetch-side handshake, the downstream handshake, the control
// strobes and the decoded output fields of decode_stage.
//   slave  : view used by decode_stage (consumes inst/in_valid/out_ready/
//            flush/resume, drives everything else)
//   master : view used by the surrounding pipeline / testbench
// Parameters must match the ones given to decode_stage.
//   RW : register-address width (also function-select width)
//   CW : width of the accepted-instruction counter
// ---------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int RW = 3,
    parameter int CW = 16
);
    localparam int IW = 4 + 4 * RW;

    // fetch side
    logic [IW-1:0]   inst;
    logic            in_valid;
    logic            in_ready;
    // control strobes
    logic            flush;
    logic            resume;
    // downstream side
    logic            out_ready;
    logic            out_valid;
    logic [RW-1:0]   dr;
    logic [RW-1:0]   sa;
    logic [RW-1:0]   sb;
    logic [RW-1:0]   fs;
    logic [2*RW-1:0] imm;
    logic            mb;
    logic            md;
    logic            ld;
    logic            mw;
    logic            hlt;
    logic            halted;
    logic [CW-1:0]   inst_cnt;

    modport slave (
        input  inst, in_valid, flush, resume, out_ready,
        output in_ready, out_valid, dr, sa, sb, fs, imm,
               mb, md, ld, mw, hlt, halted, inst_cnt
    );

    modport master (
        output inst, in_valid, flush, resume, out_ready,
        input  in_ready, out_valid, dr, sa, sb, fs, imm,
               mb, md, ld, mw, hlt, halted, inst_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered instruction-decode stage. Splits the instruction word into
// register, immediate and control fields and holds them in a single output
// register behind a valid/ready handshake. Also provides a one-bubble
// load-use hazard stall, a HALT state left via resume, and a counter of
// accepted instructions.
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous reset, active high
//   io_bus : decode_stage_if.slave
//            inst/in_valid/in_ready  - fetch handshake
//            out_valid/out_ready     - downstream handshake
//            flush, resume           - control strobes
//            dr/sa/sb/fs/imm         - decoded register fields / immediate
//            mb/md/ld/mw/hlt         - decoded control bits
//            halted, inst_cnt        - status
// Parameters:
//   RW      : register-address width; instruction width is 4 + 4*RW
//   HALT_OP : opcode that halts the stage
//   CW      : width of inst_cnt (wraps modulo 2^CW)
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int         RW      = 3,
    parameter logic [3:0] HALT_OP = 4'b0001,
    parameter int         CW      = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    decode_stage_if.slave io_bus
);
    localparam int IW = 4 + 4 * RW;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // ---------------- combinational decode of the incoming word -----------
    logic [3:0]      w_op;
    logic [RW-1:0]   w_sa;
    logic [RW-1:0]   w_dr;
    logic [RW-1:0]   w_sb_field;
    logic [RW-1:0]   w_fs_field;
    logic [2*RW-1:0] w_imm_field;
    logic            w_r_type;
    logic [RW-1:0]   w_dec_sb;
    logic [RW-1:0]   w_dec_fs;
    logic [2*RW-1:0] w_dec_imm;
    logic            w_dec_mb;
    logic            w_dec_md;
    logic            w_dec_ld;
    logic            w_dec_mw;
    logic            w_dec_hlt;

    assign w_op        = io_bus.inst[IW-1:IW-4];
    assign w_sa        = io_bus.inst[4*RW-1:3*RW];
    assign w_dr        = io_bus.inst[3*RW-1:2*RW];
    assign w_sb_field  = io_bus.inst[2*RW-1:RW];
    assign w_fs_field  = io_bus.inst[RW-1:0];
    assign w_imm_field = io_bus.inst[2*RW-1:0];
    assign w_r_type    = w_op[3];

    // R-type uses the low bits as SB/FS, I-type uses them as the immediate
    assign w_dec_sb  = w_r_type ? w_sb_field : '0;
    assign w_dec_fs  = w_r_type ? w_fs_field : '0;
    assign w_dec_imm = w_r_type ? '0 : w_imm_field;

    assign w_dec_hlt = (w_op == HALT_OP);
    assign w_dec_md  = (w_op == 4'b0010);
    // a HALT never writes memory, even if HALT_OP were set to the store opcode
    assign w_dec_mw  = (w_op == 4'b0100) && !w_dec_hlt;
    assign w_dec_ld  = !((w_op == 4'b0000) || (w_op == 4'b0100) || w_dec_hlt);
    assign w_dec_mb  = !w_op[3] && (w_op[2] | w_op[1]);

    // ---------------- output register -------------------------------------
    logic            r_out_valid;
    logic [RW-1:0]   r_dr;
    logic [RW-1:0]   r_sa;
    logic [RW-1:0]   r_sb;
    logic [RW-1:0]   r_fs;
    logic [2*RW-1:0] r_imm;
    logic            r_mb;
    logic            r_md;
    logic            r_ld;
    logic            r_mw;
    logic            r_hlt;
    logic [CW-1:0]   r_inst_cnt;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_halted;

    // ---------------- handshake -------------------------------------------
    logic w_hazard;
    logic w_in_ready;
    logic w_accept;

    // The held load's destination is not written back yet; an instruction
    // reading it must wait until the load has left this register. SB only
    // counts as a read for R-type words.
    assign w_hazard   = r_out_valid && r_md &&
                        ((w_sa == r_dr) || (w_r_type && (w_sb_field == r_dr)));
    assign w_in_ready = !w_halted && !io_bus.flush &&
                        (!r_out_valid || io_bus.out_ready) && !w_hazard;
    assign w_accept   = io_bus.in_valid && w_in_ready;

    // ---------------- FSM: state register ---------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state -------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (io_bus.flush) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_HALTED) begin
            if (io_bus.resume) begin
                w_state_next = ST_RUN;
            end
        end else if (w_accept && w_dec_hlt) begin
            w_state_next = ST_HALTED;
        end
    end

    // ---------------- FSM: outputs ----------------------------------------
    always_comb begin
        w_halted = 1'b0;
        if (r_state == ST_HALTED) begin
            w_halted = 1'b1;
        end
    end

    // ---------------- datapath register -----------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_dr        <= '0;
            r_sa        <= '0;
            r_sb        <= '0;
            r_fs        <= '0;
            r_imm       <= '0;
            r_mb        <= 1'b0;
            r_md        <= 1'b0;
            r_ld        <= 1'b0;
            r_mw        <= 1'b0;
            r_hlt       <= 1'b0;
            r_inst_cnt  <= '0;
        end else if (io_bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_dr        <= w_dr;
            r_sa        <= w_sa;
            r_sb        <= w_dec_sb;
            r_fs        <= w_dec_fs;
            r_imm       <= w_dec_imm;
            r_mb        <= w_dec_mb;
            r_md        <= w_dec_md;
            r_ld        <= w_dec_ld;
            r_mw        <= w_dec_mw;
            r_hlt       <= w_dec_hlt;
            r_inst_cnt  <= r_inst_cnt + CW'(1);
        end else if (io_bus.out_ready) begin
            // consumed downstream with nothing new behind it
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.dr        = r_dr;
    assign io_bus.sa        = r_sa;
    assign io_bus.sb        = r_sb;
    assign io_bus.fs        = r_fs;
    assign io_bus.imm       = r_imm;
    assign io_bus.mb        = r_mb;
    assign io_bus.md        = r_md;
    assign io_bus.ld        = r_ld;
    assign io_bus.mw        = r_mw;
    assign io_bus.hlt       = r_hlt;
    assign io_bus.halted    = w_halted;
    assign io_bus.inst_cnt  = r_inst_cnt;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    logic clk;
    logic rst_a;
    logic rst_b;

    int total_cnt;
    int bad_cnt;

    decode_stage_if #(.RW(3), .CW(16)) bus_a ();
    decode_stage_if #(.RW(3), .CW(4))  bus_b ();

    decode_stage #(.RW(3), .HALT_OP(4'b0001), .CW(16)) dut_a (
        .i_clk  (clk),
        .i_rst  (rst_a),
        .io_bus (bus_a.slave)
    );

    decode_stage #(.RW(3), .HALT_OP(4'b0001), .CW(4)) dut_b (
        .i_clk  (clk),
        .i_rst  (rst_b),
        .io_bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // advance one edge, then sample 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [15:0] inst, input logic vld, input logic ordy);
        bus_a.inst      = inst;
        bus_a.in_valid  = vld;
        bus_a.out_ready = ordy;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(16'h0000, 1'b0, 1'b0);
        bus_a.flush  = 1'b0;
        bus_a.resume = 1'b0;
        bus_b.inst      = 16'h0000;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        bus_b.flush     = 1'b0;
        bus_b.resume    = 1'b0;
        step();
        step();

        // ---------------- reset state ----------------
        rst_a = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("rst_halted",    32'(bus_a.halted),    32'd0);
        check_val("rst_cnt",       32'(bus_a.inst_cnt),  32'd0);
        check_val("rst_dr",        32'(bus_a.dr),        32'd0);
        check_val("rst_ld",        32'(bus_a.ld),        32'd0);
        check_val("rst_in_ready",  32'(bus_a.in_ready),  32'd1);

        // ---------------- basic R-type decode ----------------
        drive_a(16'h829D, 1'b1, 1'b1);
        step();
        check_val("r_out_valid", 32'(bus_a.out_valid), 32'd1);
        check_val("r_sa",  32'(bus_a.sa),  32'd1);
        check_val("r_dr",  32'(bus_a.dr),  32'd2);
        check_val("r_sb",  32'(bus_a.sb),  32'd3);
        check_val("r_fs",  32'(bus_a.fs),  32'd5);
        check_val("r_imm", 32'(bus_a.imm), 32'd0);
        check_val("r_mb",  32'(bus_a.mb),  32'd0);
        check_val("r_md",  32'(bus_a.md),  32'd0);
        check_val("r_ld",  32'(bus_a.ld),  32'd1);
        check_val("r_mw",  32'(bus_a.mw),  32'd0);
        check_val("r_cnt", 32'(bus_a.inst_cnt), 32'd1);

        // ---------------- back-pressure ----------------
        drive_a(16'h2700, 1'b1, 1'b1);
        step();
        check_val("ld_md",  32'(bus_a.md), 32'd1);
        check_val("ld_mb",  32'(bus_a.mb), 32'd1);
        check_val("ld_ld",  32'(bus_a.ld), 32'd1);
        check_val("ld_sa",  32'(bus_a.sa), 32'd3);
        check_val("ld_dr",  32'(bus_a.dr), 32'd4);
        check_val("ld_cnt", 32'(bus_a.inst_cnt), 32'd2);
        drive_a(16'h829D, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("bp_in_ready%0d", i), 32'(bus_a.in_ready), 32'd0);
            step();
            check_val($sformatf("bp_valid%0d", i), 32'(bus_a.out_valid), 32'd1);
            check_val($sformatf("bp_dr%0d", i),    32'(bus_a.dr),        32'd4);
            check_val($sformatf("bp_cnt%0d", i),   32'(bus_a.inst_cnt),  32'd2);
        end
        bus_a.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(bus_a.in_ready), 32'd1);
        step();
        check_val("bp_next_dr",  32'(bus_a.dr),       32'd2);
        check_val("bp_next_cnt", 32'(bus_a.inst_cnt), 32'd3);
        bus_a.in_valid = 1'b0;
        step();
        check_val("drain_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("drain_cnt",   32'(bus_a.inst_cnt),  32'd3);

        // ---------------- load-use hazard ----------------
        drive_a(16'h2700, 1'b1, 1'b1);
        step();
        check_val("hz_load_cnt", 32'(bus_a.inst_cnt), 32'd4);
        drive_a(16'h8850, 1'b1, 1'b1);
        #1;
        check_val("hz_c1_in_ready", 32'(bus_a.in_ready), 32'd0);
        step();
        check_val("hz_c2_bubble", 32'(bus_a.out_valid), 32'd0);
        check_val("hz_c2_cnt",    32'(bus_a.inst_cnt),  32'd4);
        check_val("hz_c2_in_ready", 32'(bus_a.in_ready), 32'd1);
        step();
        check_val("hz_c3_valid", 32'(bus_a.out_valid), 32'd1);
        check_val("hz_c3_sa",    32'(bus_a.sa),        32'd4);
        check_val("hz_c3_dr",    32'(bus_a.dr),        32'd1);
        check_val("hz_c3_sb",    32'(bus_a.sb),        32'd2);
        check_val("hz_c3_cnt",   32'(bus_a.inst_cnt),  32'd5);
        bus_a.in_valid = 1'b0;
        step();

        // non-dependent follower: no bubble
        drive_a(16'h2700, 1'b1, 1'b1);
        step();
        drive_a(16'h829D, 1'b1, 1'b1);
        #1;
        check_val("nohz_in_ready", 32'(bus_a.in_ready), 32'd1);
        step();
        check_val("nohz_valid", 32'(bus_a.out_valid), 32'd1);
        check_val("nohz_dr",    32'(bus_a.dr),        32'd2);
        check_val("nohz_cnt",   32'(bus_a.inst_cnt),  32'd7);

        // ---------------- store / halt ----------------
        drive_a(16'h4000, 1'b1, 1'b1);
        step();
        check_val("st_ld", 32'(bus_a.ld), 32'd0);
        check_val("st_mw", 32'(bus_a.mw), 32'd1);
        check_val("st_mb", 32'(bus_a.mb), 32'd1);
        check_val("st_md", 32'(bus_a.md), 32'd0);
        drive_a(16'h1000, 1'b1, 1'b1);
        step();
        check_val("ht_hlt",    32'(bus_a.hlt),       32'd1);
        check_val("ht_ld",     32'(bus_a.ld),        32'd0);
        check_val("ht_mw",     32'(bus_a.mw),        32'd0);
        check_val("ht_halted", 32'(bus_a.halted),    32'd1);
        check_val("ht_valid",  32'(bus_a.out_valid), 32'd1);
        check_val("ht_cnt",    32'(bus_a.inst_cnt),  32'd9);
        drive_a(16'h829D, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("ht_in_ready%0d", i), 32'(bus_a.in_ready), 32'd0);
            step();
        end
        check_val("ht_drained", 32'(bus_a.out_valid), 32'd0);
        check_val("ht_cnt_hold", 32'(bus_a.inst_cnt), 32'd9);
        bus_a.resume = 1'b1;
        #1;
        check_val("rs_cycle_in_ready", 32'(bus_a.in_ready), 32'd0);
        step();
        bus_a.resume = 1'b0;
        #1;
        check_val("rs_halted",   32'(bus_a.halted),   32'd0);
        check_val("rs_in_ready", 32'(bus_a.in_ready), 32'd1);
        step();
        check_val("rs_accept_cnt", 32'(bus_a.inst_cnt), 32'd10);

        // ---------------- flush ----------------
        drive_a(16'h829D, 1'b0, 1'b0);
        bus_a.flush = 1'b1;
        #1;
        check_val("fl_in_ready", 32'(bus_a.in_ready), 32'd0);
        step();
        bus_a.flush = 1'b0;
        check_val("fl_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("fl_cnt",   32'(bus_a.inst_cnt),  32'd10);

        drive_a(16'h1000, 1'b1, 1'b1);
        step();
        check_val("flh_halted_pre", 32'(bus_a.halted), 32'd1);
        bus_a.in_valid = 1'b0;
        bus_a.flush    = 1'b1;
        step();
        bus_a.flush = 1'b0;
        #1;
        check_val("flh_halted", 32'(bus_a.halted),    32'd0);
        check_val("flh_valid",  32'(bus_a.out_valid), 32'd0);
        check_val("flh_cnt",    32'(bus_a.inst_cnt),  32'd11);
        check_val("flh_in_ready", 32'(bus_a.in_ready), 32'd1);

        // ---------------- reset mid-stall ----------------
        drive_a(16'h2700, 1'b1, 1'b0);
        step();
        bus_a.in_valid = 1'b0;
        step();
        check_val("ms_valid_pre", 32'(bus_a.out_valid), 32'd1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check_val("ms_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("ms_cnt",   32'(bus_a.inst_cnt),  32'd0);
        check_val("ms_md",    32'(bus_a.md),        32'd0);
        check_val("ms_dr",    32'(bus_a.dr),        32'd0);

        // ---------------- counter wrap, CW=4 ----------------
        rst_b = 1'b0;
        #1;
        check_val("w_rst_cnt", 32'(bus_b.inst_cnt), 32'd0);
        bus_b.inst      = 16'h829D;
        bus_b.in_valid  = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val($sformatf("w_cnt%0d", i), 32'(bus_b.inst_cnt), 32'(i % 16));
        end
        for (int i = 1; i <= 3; i++) begin
            step();
        end
        check_val("w_mid_cnt", 32'(bus_b.inst_cnt), 32'd3);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        bus_b.in_valid = 1'b0;
        check_val("w_rst_mid_cnt",   32'(bus_b.inst_cnt),  32'd0);
        check_val("w_rst_mid_valid", 32'(bus_b.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
